// File: rtl/setup_complex_fir_coeff.sv
// Streams a fixed table of complex FIR taps, one per enabled clock, then raises
// a sticky completion flag so the downstream FIR knows its coefficients are loaded.
module setup_complex_fir_coeff #(
    parameter int unsigned LENGTH     = 20,
    parameter int unsigned DATA_WIDTH = 18
) (
    input  logic                         clock,
    input  logic                         resetN,
    input  logic                         enable,
    output logic                         coeffSetFlag,
    output logic signed [DATA_WIDTH-1:0] coeffOutRe,
    output logic signed [DATA_WIDTH-1:0] coeffOutIm
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [5:0] LEN = 6'(LENGTH);

    state_t                       state_q, state_d;
    logic   [5:0]                 idx_q, idx_d;
    logic                         flag_q, flag_d;
    logic   signed [DATA_WIDTH-1:0] re_q, re_d;
    logic   signed [DATA_WIDTH-1:0] im_q, im_d;

    logic   signed [DATA_WIDTH-1:0] tap_re, tap_im;
    logic   [5:0]                 tap_sel;

    function automatic logic [35:0] pk(input int re, input int im);
        return {18'(re), 18'(im)};
    endfunction

    // Master table is 18-bit; narrower widths keep the low bits, wider ones sign-extend.
    function automatic logic [35:0] tap_tbl(input logic [5:0] k);
        case (k)
            6'd0:    return pk(34124, -7392);
            6'd1:    return pk(34124, 15);
            6'd2:    return pk(0, 89998);
            6'd3:    return pk(4991, -43211);
            6'd4:    return pk(12522, -131072);
            6'd5:    return pk(-7711, 131071);
            6'd6:    return pk(-5151, 5151);
            6'd7:    return pk(81122, 81122);
            6'd8:    return pk(9890, 0);
            6'd9:    return pk(1091, 882);
            6'd10:   return pk(-9111, -9);
            6'd11:   return pk(-10369, 8982);
            6'd12:   return pk(911, -119);
            6'd13:   return pk(1121, 6969);
            6'd14:   return pk(591, -666);
            6'd15:   return pk(7590, 8422);
            6'd16:   return pk(19, -19223);
            6'd17:   return pk(5811, -131072);
            6'd18:   return pk(-970, -9790);
            6'd19:   return pk(10000, 1);
            default: return '0;
        endcase
    endfunction

    logic [35:0] tap_word;

    always_comb begin
        tap_word = tap_tbl(tap_sel);
        tap_re   = DATA_WIDTH'($signed(tap_word[35:18]));
        tap_im   = DATA_WIDTH'($signed(tap_word[17:0]));
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        flag_d  = flag_q;
        re_d    = re_q;
        im_d    = im_q;
        tap_sel = '0;
        case (state_q)
            IDLE: begin
                re_d = '0;
                im_d = '0;
                if (enable) begin
                    re_d    = tap_re;
                    im_d    = tap_im;
                    idx_d   = 6'd1;
                    state_d = RUN;
                end
            end
            RUN: begin
                tap_sel = idx_q;
                if (enable) begin
                    if (idx_q < LEN) begin
                        re_d  = tap_re;
                        im_d  = tap_im;
                        idx_d = idx_q + 6'd1;
                    end else begin
                        re_d    = '0;
                        im_d    = '0;
                        flag_d  = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                re_d   = '0;
                im_d   = '0;
                flag_d = 1'b1;
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
                flag_d  = 1'b0;
                re_d    = '0;
                im_d    = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state_q <= IDLE;
            idx_q   <= '0;
            flag_q  <= 1'b0;
            re_q    <= '0;
            im_q    <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            flag_q  <= flag_d;
            re_q    <= re_d;
            im_q    <= im_d;
        end
    end

    assign coeffSetFlag = flag_q;
    assign coeffOutRe   = re_q;
    assign coeffOutIm   = im_q;

endmodule

// File: tb/tb_setup_complex_fir_coeff.sv
// Directed bench for setup_complex_fir_coeff at the default LENGTH=20, DATA_WIDTH=18.
module tb_setup_complex_fir_coeff;

    logic               clock;
    logic               resetN;
    logic               enable;
    logic               coeffSetFlag;
    logic signed [17:0] coeffOutRe;
    logic signed [17:0] coeffOutIm;

    int vectors;
    int miscompares;

    int re_tab[20] = '{34124, 34124, 0, 4991, 12522, -7711, -5151, 81122, 9890, 1091,
                       -9111, -10369, 911, 1121, 591, 7590, 19, 5811, -970, 10000};
    int im_tab[20] = '{-7392, 15, 89998, -43211, -131072, 131071, 5151, 81122, 0, 882,
                       -9, 8982, -119, 6969, -666, 8422, -19223, -131072, -9790, 1};

    setup_complex_fir_coeff #(
        .LENGTH     (20),
        .DATA_WIDTH (18)
    ) dut (
        .clock        (clock),
        .resetN       (resetN),
        .enable       (enable),
        .coeffSetFlag (coeffSetFlag),
        .coeffOutRe   (coeffOutRe),
        .coeffOutIm   (coeffOutIm)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input int re, input int im, input int flag);
        check({tag, ".re"}, int'(coeffOutRe), re);
        check({tag, ".im"}, int'(coeffOutIm), im);
        check({tag, ".flag"}, int'(coeffSetFlag), flag);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        resetN = 1'b0;
        enable = 1'b0;
        #1;
        check_out("reset", 0, 0, 0);
        tick();
        resetN = 1'b1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        resetN      = 1'b1;
        enable      = 1'b0;
        #2;

        // Reset, then enable held low for 10 cycles
        do_reset();
        for (int i = 0; i < 10; i++) begin
            tick();
            check_out("idle", 0, 0, 0);
        end

        // Full stream with enable held high
        enable = 1'b1;
        tick();
        for (int k = 0; k < 20; k++) begin
            check_out($sformatf("tap%0d", k), re_tab[k], im_tab[k], 0);
            tick();
        end
        check_out("done", 0, 0, 1);
        check("tap4_im_min", (-131072), im_tab[4]);

        // DONE ignores enable toggling
        for (int i = 0; i < 8; i++) begin
            enable = ~enable;
            tick();
            check_out("done_toggle", 0, 0, 1);
        end

        // Pause on tap 7 for 3 cycles
        do_reset();
        check_out("reset2_idle", 0, 0, 0);
        enable = 1'b1;
        tick();
        for (int k = 0; k < 7; k++) tick();
        check_out("pause_tap7", 81122, 81122, 0);
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_out("hold_tap7", 81122, 81122, 0);
        end
        enable = 1'b1;
        tick();
        for (int k = 8; k < 20; k++) begin
            check_out($sformatf("resume_tap%0d", k), re_tab[k], im_tab[k], 0);
            tick();
        end
        check_out("pause_done", 0, 0, 1);

        // Asynchronous reset mid-stream while tap 10 is presented
        do_reset();
        enable = 1'b1;
        tick();
        for (int k = 0; k < 10; k++) tick();
        check_out("pre_abort_tap10", -9111, -9, 0);
        #2;
        resetN = 1'b0;
        #1;
        check_out("abort_async", 0, 0, 0);
        enable = 1'b0;
        tick();
        check_out("abort_held", 0, 0, 0);
        resetN = 1'b1;
        tick();
        check_out("abort_idle", 0, 0, 0);
        enable = 1'b1;
        tick();
        for (int k = 0; k < 20; k++) begin
            check_out($sformatf("restart_tap%0d", k), re_tab[k], im_tab[k], 0);
            tick();
        end
        check_out("restart_done", 0, 0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
